// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART link-layer controller: header layout,
// frame type codes, FSM state encodings and a header builder.
package uart_link_pkg;

  // Header byte field positions
  localparam int HDR_TYPE_HI = 7;
  localparam int HDR_TYPE_LO = 6;
  localparam int HDR_SRC_HI  = 5;
  localparam int HDR_SRC_LO  = 4;
  localparam int HDR_DST_HI  = 3;
  localparam int HDR_DST_LO  = 2;
  localparam int HDR_MRK_HI  = 1;
  localparam int HDR_MRK_LO  = 0;

  // Frame type codes and the fixed low-bit marker
  localparam logic [1:0] TYPE_DATA = 2'b01;
  localparam logic [1:0] TYPE_ACK  = 2'b10;
  localparam logic [1:0] MARKER    = 2'b11;

  typedef enum logic [2:0] {
    T_IDLE   = 3'd0,
    T_HDR    = 3'd1,
    T_HDR_W  = 3'd2,
    T_PAY    = 3'd3,
    T_PAY_W  = 3'd4,
    T_ACK_W  = 3'd5,
    T_AHDR   = 3'd6,
    T_AHDR_W = 3'd7
  } tx_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_PAY  = 1'b1
  } rx_state_e;

  // Assemble a header byte from its fields
  function automatic logic [7:0] make_hdr(input logic [1:0] typ,
                                          input logic [1:0] src,
                                          input logic [1:0] dst);
    return {typ, src, dst, MARKER};
  endfunction

endpackage

// File: rtl/link_timeout_ctr.sv
// Saturating down-counter timeout. load presets TIMEOUT-1, en counts down,
// expired is high while the count sits at zero (it never wraps).
module link_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise decrement until zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_link_ctrl.sv
// Link-layer controller: shares one uart_tx core between user DATA frames
// and automatic ACK replies, filters Rx frames by node ID, and retries
// unacknowledged sends.
//
// Byte-core handshakes: tx_start is a one-cycle load strobe with tx_data
// held until tx_busy falls; tx_busy is not trusted in the first cycle after
// tx_start because the core raises it one cycle late. rx_valid is a
// one-cycle strobe qualifying rx_data; there is no back-pressure on Rx.
module uart_link_ctrl
  import uart_link_pkg::*;
#(
  parameter int ACK_TIMEOUT  = 5_000_000,
  parameter int BYTE_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] my_id,
  input  logic [1:0] dst_id,
  input  logic [7:0] tx_payload,
  input  logic       send_req,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] msg_data,
  output logic       msg_valid,
  output logic       ack_ok,
  output logic       err_nack,
  output logic       busy,
  output tx_state_e  dbg_tx_state,
  output rx_state_e  dbg_rx_state
);

  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Button synchronizer and edge detector
  logic sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, press_q, press_d;

  // TX side
  tx_state_e    tx_state_q, tx_state_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic [1:0]   dst_lat_q, dst_lat_d;
  logic [7:0]   pay_lat_q, pay_lat_d;
  logic [RCW-1:0] retry_q, retry_d;
  logic         ack_ok_q, ack_ok_d;
  logic         err_nack_q, err_nack_d;
  logic         busy_q, busy_d;
  logic         ret_ackw_q, ret_ackw_d;   // ACK being sent was entered from T_ACK_W
  logic         got_ack_q, got_ack_d;     // matching ACK seen while our ACK was on the wire
  logic         w_first_q, w_first_d;     // first cycle of a *_W state
  logic         ack_take;
  logic         ack_load, ack_en, ack_exp;

  // RX side
  rx_state_e    rx_state_q, rx_state_d;
  logic [1:0]   rx_src_q, rx_src_d;
  logic [7:0]   msg_data_q, msg_data_d;
  logic         msg_valid_q, msg_valid_d;
  logic         ack_pending_q, ack_pending_d;
  logic [1:0]   ack_dst_q, ack_dst_d;
  logic         pay_accept;
  logic         byte_load, byte_en, byte_exp;

  // Header field decode
  logic [1:0] rx_type, rx_src, rx_dst, rx_mrk;
  logic       data_hit, ack_hit, w_done, in_ahdr;

  assign rx_type = rx_data[HDR_TYPE_HI:HDR_TYPE_LO];
  assign rx_src  = rx_data[HDR_SRC_HI:HDR_SRC_LO];
  assign rx_dst  = rx_data[HDR_DST_HI:HDR_DST_LO];
  assign rx_mrk  = rx_data[HDR_MRK_HI:HDR_MRK_LO];

  assign data_hit = rx_valid && (rx_state_q == R_IDLE) && (rx_type == TYPE_DATA) &&
                    (rx_mrk == MARKER) && (rx_dst == my_id);
  assign ack_hit  = rx_valid && (rx_state_q == R_IDLE) && (rx_type == TYPE_ACK) &&
                    (rx_mrk == MARKER) && (rx_dst == my_id) && (rx_src == dst_lat_q);

  assign tx_start = (tx_state_q == T_HDR) || (tx_state_q == T_PAY) || (tx_state_q == T_AHDR);
  assign w_done   = !w_first_q && !tx_busy;
  assign in_ahdr  = (tx_state_q == T_AHDR) || (tx_state_q == T_AHDR_W);
  assign ack_en   = (tx_state_q == T_ACK_W) || (ret_ackw_q && in_ahdr);
  assign byte_en  = (rx_state_q == R_PAY);

  link_timeout_ctr #(.TIMEOUT(ACK_TIMEOUT)) u_ack_tmr (
    .clk     (clk),
    .reset   (reset),
    .load    (ack_load),
    .en      (ack_en),
    .expired (ack_exp)
  );

  link_timeout_ctr #(.TIMEOUT(BYTE_TIMEOUT)) u_byte_tmr (
    .clk     (clk),
    .reset   (reset),
    .load    (byte_load),
    .en      (byte_en),
    .expired (byte_exp)
  );

  // Two-flop synchronizer followed by a registered rising-edge pulse
  always_comb begin
    sync1_d = send_req;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    press_d = sync2_q && !sync3_q;
  end

  // RX FSM: header filter, payload capture, byte timeout
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_src_d    = rx_src_q;
    msg_data_d  = msg_data_q;
    msg_valid_d = 1'b0;
    byte_load   = 1'b0;
    pay_accept  = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (data_hit) begin
          rx_src_d   = rx_src;
          byte_load  = 1'b1;
          rx_state_d = R_PAY;
        end
      end
      R_PAY: begin
        if (rx_valid) begin
          msg_data_d  = rx_data;
          msg_valid_d = 1'b1;
          pay_accept  = 1'b1;
          rx_state_d  = R_IDLE;
        end else if (byte_exp) begin
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Pending ACK: a newly accepted payload overrides the take-out by the TX FSM
  always_comb begin
    ack_pending_d = ack_pending_q;
    ack_dst_d     = ack_dst_q;
    if (ack_take) begin
      ack_pending_d = 1'b0;
    end
    if (pay_accept) begin
      ack_pending_d = 1'b1;
      ack_dst_d     = rx_src_q;
    end
  end

  // TX FSM: user send with retries, ACK replies with priority, return to entry state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    dst_lat_d  = dst_lat_q;
    pay_lat_d  = pay_lat_q;
    retry_d    = retry_q;
    ack_ok_d   = ack_ok_q;
    err_nack_d = err_nack_q;
    busy_d     = busy_q;
    ret_ackw_d = ret_ackw_q;
    got_ack_d  = got_ack_q;
    w_first_d  = tx_start;
    ack_take   = 1'b0;
    ack_load   = 1'b0;
    case (tx_state_q)
      T_IDLE: begin
        if (ack_pending_q) begin
          ack_take   = 1'b1;
          ret_ackw_d = 1'b0;
          tx_data_d  = make_hdr(TYPE_ACK, my_id, ack_dst_q);
          tx_state_d = T_AHDR;
        end else if (press_q) begin
          dst_lat_d  = dst_id;
          pay_lat_d  = tx_payload;
          ack_ok_d   = 1'b0;
          err_nack_d = 1'b0;
          retry_d    = '0;
          busy_d     = 1'b1;
          tx_data_d  = make_hdr(TYPE_DATA, my_id, dst_id);
          tx_state_d = T_HDR;
        end
      end
      T_HDR:   tx_state_d = T_HDR_W;
      T_HDR_W: begin
        if (w_done) begin
          tx_data_d  = pay_lat_q;
          tx_state_d = T_PAY;
        end
      end
      T_PAY:   tx_state_d = T_PAY_W;
      T_PAY_W: begin
        if (w_done) begin
          ack_load   = 1'b1;
          got_ack_d  = 1'b0;
          tx_state_d = T_ACK_W;
        end
      end
      T_ACK_W: begin
        if (ack_hit || got_ack_q) begin
          ack_ok_d   = 1'b1;
          busy_d     = 1'b0;
          got_ack_d  = 1'b0;
          tx_state_d = T_IDLE;
        end else if (ack_pending_q) begin
          ack_take   = 1'b1;
          ret_ackw_d = 1'b1;
          tx_data_d  = make_hdr(TYPE_ACK, my_id, ack_dst_q);
          tx_state_d = T_AHDR;
        end else if (ack_exp) begin
          if (retry_q < RCW'(MAX_RETRY)) begin
            retry_d    = retry_q + RCW'(1);
            tx_data_d  = make_hdr(TYPE_DATA, my_id, dst_lat_q);
            tx_state_d = T_HDR;
          end else begin
            err_nack_d = 1'b1;
            busy_d     = 1'b0;
            tx_state_d = T_IDLE;
          end
        end
      end
      T_AHDR:   tx_state_d = T_AHDR_W;
      T_AHDR_W: begin
        if (w_done) begin
          tx_state_d = ret_ackw_q ? T_ACK_W : T_IDLE;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
    if (ack_hit && ret_ackw_q && in_ahdr) begin
      got_ack_d = 1'b1;
    end
  end

  // State and output registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      press_q       <= 1'b0;
      tx_state_q    <= T_IDLE;
      tx_data_q     <= '0;
      dst_lat_q     <= '0;
      pay_lat_q     <= '0;
      retry_q       <= '0;
      ack_ok_q      <= 1'b0;
      err_nack_q    <= 1'b0;
      busy_q        <= 1'b0;
      ret_ackw_q    <= 1'b0;
      got_ack_q     <= 1'b0;
      w_first_q     <= 1'b0;
      rx_state_q    <= R_IDLE;
      rx_src_q      <= '0;
      msg_data_q    <= '0;
      msg_valid_q   <= 1'b0;
      ack_pending_q <= 1'b0;
      ack_dst_q     <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      press_q       <= press_d;
      tx_state_q    <= tx_state_d;
      tx_data_q     <= tx_data_d;
      dst_lat_q     <= dst_lat_d;
      pay_lat_q     <= pay_lat_d;
      retry_q       <= retry_d;
      ack_ok_q      <= ack_ok_d;
      err_nack_q    <= err_nack_d;
      busy_q        <= busy_d;
      ret_ackw_q    <= ret_ackw_d;
      got_ack_q     <= got_ack_d;
      w_first_q     <= w_first_d;
      rx_state_q    <= rx_state_d;
      rx_src_q      <= rx_src_d;
      msg_data_q    <= msg_data_d;
      msg_valid_q   <= msg_valid_d;
      ack_pending_q <= ack_pending_d;
      ack_dst_q     <= ack_dst_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign msg_data     = msg_data_q;
  assign msg_valid    = msg_valid_q;
  assign ack_ok       = ack_ok_q;
  assign err_nack     = err_nack_q;
  assign busy         = busy_q;
  assign dbg_tx_state = tx_state_q;
  assign dbg_rx_state = rx_state_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl with a peer-side frame model, a uart_tx
// stand-in, and a per-cycle scoreboard on transmitted bytes and messages.
module tb_uart_link_ctrl;
  import uart_link_pkg::*;

  localparam int AT       = 300;
  localparam int BT       = 40;
  localparam int MR       = 3;
  localparam int BUSY_CYC = 10;

  logic       clk;
  logic       reset;
  logic [1:0] my_id, dst_id;
  logic [7:0] tx_payload;
  logic       send_req;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] msg_data;
  logic       msg_valid;
  logic       ack_ok, err_nack, busy;
  tx_state_e  dbg_tx_state;
  rx_state_e  dbg_rx_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] msg_q[$];
  logic [7:0] cap_byte;
  int         cap_rc;

  uart_link_ctrl #(
    .ACK_TIMEOUT (AT),
    .BYTE_TIMEOUT(BT),
    .MAX_RETRY   (MR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .my_id       (my_id),
    .dst_id      (dst_id),
    .tx_payload  (tx_payload),
    .send_req    (send_req),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .msg_data    (msg_data),
    .msg_valid   (msg_valid),
    .ack_ok      (ack_ok),
    .err_nack    (err_nack),
    .busy        (busy),
    .dbg_tx_state(dbg_tx_state),
    .dbg_rx_state(dbg_rx_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [7:0] hdr(input int typ, input int src, input int dst);
    return 8'((typ * 64) + (src * 16) + (dst * 4) + 3);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard: every transmitted byte and message ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (tx_start) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_tx_start: got %02h expected none", tx_data);
          end else begin
            check("tx_byte", tx_data, exp_q.pop_front());
          end
        end
        if (msg_valid) begin
          if (msg_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_msg_valid: got %02h expected none", msg_data);
          end else begin
            check("msg_byte", msg_data, msg_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- uart_tx stand-in ----------------
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && tx_start) begin
        cap_byte = tx_data;
        cap_rc   = rst_count;
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1;
        if (cap_rc == rst_count) check("tx_data_stable", tx_data, cap_byte);
        tx_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  // Press the button; tx_start must appear after the third edge past the first sample
  task automatic press(input string name);
    int k;
    k = 0;
    @(posedge clk);
    #1 send_req = 1'b1;
    @(posedge clk);
    while (k < 8) begin
      @(posedge clk);
      #1;
      k++;
      if (tx_start) break;
    end
    check(name, k, 3);
    send_req = 1'b0;
  endtask

  // Wait until all expected bytes went out and the byte core is quiet
  task automatic wait_idle(input int max_cyc, input string name);
    int stable;
    int n;
    stable = 0;
    n = 0;
    while (stable < 3 && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && !tx_busy && !tx_start) stable++;
      else stable = 0;
    end
    check(name, (stable >= 3), 1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int c;
    reset      = 1'b0;
    send_req   = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    my_id      = 2'b01;
    dst_id     = 2'b10;
    tx_payload = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_msg_data", msg_data, 0);
    check("rst_msg_valid", msg_valid, 0);
    check("rst_ack_ok", ack_ok, 0);
    check("rst_err_nack", err_nack, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    settle();

    // T1: acknowledged send; literal bytes pin the header model
    tx_payload = 8'h5A;
    exp_q.push_back(8'h5B);
    exp_q.push_back(8'h5A);
    press("t1_latency");
    check("t1_busy", busy, 1);
    wait_idle(200, "t1_drain");
    @(posedge clk);
    #1 send_req = 1'b1;          // press while busy: must be dropped
    repeat (6) @(posedge clk);
    #1 send_req = 1'b0;
    rx_byte(8'h87);              // ACK from node 00, not from the addressee
    settle();
    check("t1_wrong_src_ack", ack_ok, 0);
    check("t1_busy_hold", busy, 1);
    rx_byte(8'hA7);              // ACK 10 -> 01
    settle();
    check("t1_ack_ok", ack_ok, 1);
    check("t1_busy_clear", busy, 0);
    check("t1_err_nack", err_nack, 0);

    // T2: no ACK -> first attempt plus MR retries, then err_nack
    for (int i = 0; i <= MR; i++) begin
      exp_q.push_back(hdr(1, 1, 2));
      exp_q.push_back(8'h5A);
    end
    press("t2_latency");
    check("t2_ack_ok_cleared", ack_ok, 0);
    check("t2_busy", busy, 1);
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin @(negedge clk); n++; end
    check("t2_all_frames", exp_q.size(), 0);
    check("t2_err_before_last", err_nack, 0);
    n = 0;
    while (!tx_busy && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (tx_busy && n < 50) begin @(negedge clk); n++; end
    c = 0;
    while (!err_nack && c < AT + 20) begin @(negedge clk); c++; end
    check("t2_err_gap_ok", (c >= AT && c <= AT + 3), 1);
    check("t2_err_nack", err_nack, 1);
    check("t2_busy_clear", busy, 0);
    check("t2_ack_ok", ack_ok, 0);
    repeat (AT + 20) @(posedge clk);   // no fifth attempt may follow

    // T3: DATA from node 10 to us -> message plus ACK back to 10
    exp_q.push_back(hdr(2, 1, 2));
    msg_q.push_back(8'hC3);
    rx_byte(8'h67);
    rx_byte(8'hC3);
    wait_idle(200, "t3_drain");
    check("t3_msg_data", msg_data, 8'hC3);

    // T4: filtering and byte timeout
    rx_byte(8'h6B);              // addressed to node 10
    rx_byte(8'h55);              // not a header
    settle();
    check("t4_foreign_ignored", msg_data, 8'hC3);
    rx_byte(8'h67);
    repeat (BT + 10) @(posedge clk);
    rx_byte(8'hC3);              // late byte, now read as an invalid header
    settle();
    check("t4_timeout_discard", msg_data, 8'hC3);
    exp_q.push_back(hdr(2, 1, 2));
    msg_q.push_back(8'h22);
    rx_byte(8'h67);
    repeat (BT - 10) @(posedge clk);
    rx_byte(8'h22);
    wait_idle(200, "t4_drain_in_time");
    check("t4_in_time_payload", msg_data, 8'h22);
    exp_q.push_back(hdr(2, 1, 3));
    msg_q.push_back(8'h99);
    rx_byte(8'h77);              // DATA from node 11
    rx_byte(8'h99);
    wait_idle(200, "t4_drain_src3");
    check("t4_src3_payload", msg_data, 8'h99);

    // T5: DATA arrives while waiting for our ACK
    tx_payload = 8'h3C;
    exp_q.push_back(hdr(1, 1, 2));
    exp_q.push_back(8'h3C);
    press("t5_latency");
    check("t5_err_cleared", err_nack, 0);
    wait_idle(200, "t5_drain");
    exp_q.push_back(hdr(2, 1, 2));
    msg_q.push_back(8'h44);
    rx_byte(8'h67);
    rx_byte(8'h44);
    wait_idle(200, "t5_ack_mid_wait");
    check("t5_busy_still", busy, 1);
    check("t5_not_acked_yet", ack_ok, 0);
    rx_byte(hdr(2, 2, 1));
    settle();
    check("t5_ack_ok", ack_ok, 1);
    check("t5_busy_clear", busy, 0);
    check("t5_err_nack", err_nack, 0);

    // T6: reset while the payload is on the wire
    tx_payload = 8'h77;
    exp_q.push_back(hdr(1, 1, 2));
    exp_q.push_back(8'h77);
    press("t6_latency");
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (!tx_busy && n < 50) begin @(negedge clk); n++; end
    check("t6_in_payload", tx_busy, 1);
    #2;
    rst_count++;
    reset = 1'b0;
    #1;
    check("t6_tx_start", tx_start, 0);
    check("t6_tx_data", tx_data, 0);
    check("t6_busy", busy, 0);
    check("t6_ack_ok", ack_ok, 0);
    check("t6_err_nack", err_nack, 0);
    check("t6_msg_data", msg_data, 0);
    check("t6_msg_valid", msg_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (tx_busy && n < 50) begin @(negedge clk); n++; end
    tx_payload = 8'h12;
    exp_q.push_back(hdr(1, 1, 2));
    exp_q.push_back(8'h12);
    press("t6_fresh_latency");
    wait_idle(200, "t6_drain");
    rx_byte(hdr(2, 2, 1));
    settle();
    check("t6_ack_ok", ack_ok, 1);
    check("t6_busy_clear", busy, 0);

    repeat (20) @(posedge clk);
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_msg_q_empty", msg_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
